// File: rtl/split_stream_fifo_n_pkg.sv
// Shared constants and FSM encoding for the N-way stream splitter.
package split_stream_fifo_n_pkg;

  // Width of each per-output dropped-packet counter
  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

endpackage

// File: rtl/split_stream_fifo_n_if.sv
// Stream bundle for the splitter: one input stream, N output streams, drop counters.
interface split_stream_fifo_n_if #(
  parameter int WIDTH       = 16,
  parameter int NUM_OUTPUTS = 4
);
  import split_stream_fifo_n_pkg::*;

  logic [NUM_OUTPUTS-1:0]       en_mask;
  logic [WIDTH-1:0]             i_tdata;
  logic                         i_tlast;
  logic                         i_tvalid;
  logic                         i_tready;
  logic [NUM_OUTPUTS*WIDTH-1:0] o_tdata;
  logic [NUM_OUTPUTS-1:0]       o_tlast;
  logic [NUM_OUTPUTS-1:0]       o_tvalid;
  logic [NUM_OUTPUTS-1:0]       o_tready;
  logic [NUM_OUTPUTS*CNT_W-1:0] drop_count;

  // Producer/consumer side (drives input stream and output readies)
  modport master (
    output en_mask, i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid, drop_count
  );

  // Splitter side
  modport slave (
    input  en_mask, i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid, drop_count
  );

endinterface

// File: rtl/axi_fifo.sv
// Simple 2**SIZE-deep stream FIFO; output valid the cycle after a push lands.
module axi_fifo #(
  parameter int WIDTH = 17,
  parameter int SIZE  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready
);
  localparam int DEPTH = 1 << SIZE;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SIZE:0]    wr_ptr, rd_ptr;
  logic             full, empty;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[SIZE] != rd_ptr[SIZE]) &&
                    (wr_ptr[SIZE-1:0] == rd_ptr[SIZE-1:0]);
  assign i_tready = ~full;
  assign o_tvalid = ~empty;
  assign o_tdata  = mem[rd_ptr[SIZE-1:0]];

  // Storage array is data only and carries no reset
  always_ff @(posedge clk) begin
    if (i_tvalid && !full) mem[wr_ptr[SIZE-1:0]] <= i_tdata;
  end

  // Read/write pointers; clear flushes without touching storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_tvalid && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (o_tready && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/split_stream_fifo_n_fanout.sv
// Broadcast control: packet FSM, per-packet mask latch, per-output taken bits, drop counters.
module split_stream_fanout
  import split_stream_fifo_n_pkg::*;
#(
  parameter int                     NUM_OUTPUTS = 4,
  parameter logic [NUM_OUTPUTS-1:0] ACTIVE_MASK = {NUM_OUTPUTS{1'b1}},
  parameter int                     DROP_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic [NUM_OUTPUTS-1:0]       en_mask,
  input  logic                         i_tvalid,
  input  logic                         i_tlast,
  output logic                         i_tready,
  input  logic [NUM_OUTPUTS-1:0]       fifo_rdy,
  output logic [NUM_OUTPUTS-1:0]       push,
  output logic [NUM_OUTPUTS*CNT_W-1:0] drop_count
);
  state_t                 state;
  logic [NUM_OUTPUTS-1:0] cur_mask, taken, pm, mask, accepted, drop_hit;
  logic                   idle, latch, complete, beat_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // In DROP_MODE a full FIFO at packet start is excluded for the whole packet
  assign pm        = en_mask & ACTIVE_MASK &
                     ((DROP_MODE != 0) ? fifo_rdy : {NUM_OUTPUTS{1'b1}});
  assign drop_hit  = (DROP_MODE != 0) ? (en_mask & ACTIVE_MASK & ~fifo_rdy) : '0;
  assign idle      = (state == IDLE);
  assign latch     = idle & i_tvalid;
  assign mask      = idle ? pm : cur_mask;
  assign push      = {NUM_OUTPUTS{i_tvalid & ~clear}} & mask & ~taken;
  assign accepted  = push & fifo_rdy;
  assign complete  = &(~mask | taken | fifo_rdy);
  assign beat_done = i_tvalid & complete;
  assign i_tready  = reset_n & ~clear & complete;

  // Packet FSM, mask latch, taken tracking and saturating drop counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur_mask   <= '0;
      taken      <= '0;
      drop_count <= '0;
    end else if (clear) begin
      state    <= IDLE;
      cur_mask <= '0;
      taken    <= '0;
    end else begin
      if (latch) begin
        cur_mask <= pm;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
          if (drop_hit[k])
            drop_count[k*CNT_W +: CNT_W] <= sat_inc(drop_count[k*CNT_W +: CNT_W]);
        end
      end
      if (beat_done) begin
        taken <= '0;
        state <= i_tlast ? IDLE : PKT;
      end else begin
        taken <= taken | accepted;
        if (latch) state <= PKT;
      end
    end
  end

endmodule

// File: rtl/split_stream_fifo_n.sv
// N-way stream packet broadcaster with a FIFO per built output.
module split_stream_fifo_n
  import split_stream_fifo_n_pkg::*;
#(
  parameter int                     WIDTH       = 16,
  parameter int                     NUM_OUTPUTS = 4,
  parameter int                     FIFO_SIZE   = 5,
  parameter logic [NUM_OUTPUTS-1:0] ACTIVE_MASK = {NUM_OUTPUTS{1'b1}},
  parameter int                     DROP_MODE   = 0
) (
  input logic                  clk,
  input logic                  reset_n,
  input logic                  clear,
  split_stream_fifo_n_if.slave bus
);
  logic [NUM_OUTPUTS-1:0] fifo_rdy, push;

  split_stream_fanout #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .ACTIVE_MASK (ACTIVE_MASK),
    .DROP_MODE   (DROP_MODE)
  ) u_fanout (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .en_mask    (bus.en_mask),
    .i_tvalid   (bus.i_tvalid),
    .i_tlast    (bus.i_tlast),
    .i_tready   (bus.i_tready),
    .fifo_rdy   (fifo_rdy),
    .push       (push),
    .drop_count (bus.drop_count)
  );

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_out
    if (ACTIVE_MASK[k]) begin : g_built
      logic [WIDTH:0] q_data;
      logic           q_vld;

      // {tlast,tdata} travel together through the FIFO
      axi_fifo #(.WIDTH(WIDTH + 1), .SIZE(FIFO_SIZE)) u_fifo (
        .clk      (clk),
        .reset    (~reset_n),
        .clear    (clear),
        .i_tdata  ({bus.i_tlast, bus.i_tdata}),
        .i_tvalid (push[k]),
        .i_tready (fifo_rdy[k]),
        .o_tdata  (q_data),
        .o_tvalid (q_vld),
        .o_tready (bus.o_tready[k])
      );

      // Data and last are forced to zero whenever the output is idle
      assign bus.o_tvalid[k]                  = q_vld;
      assign bus.o_tlast[k]                   = q_vld & q_data[WIDTH];
      assign bus.o_tdata[k*WIDTH +: WIDTH]    = q_vld ? q_data[WIDTH-1:0] : '0;
    end else begin : g_unbuilt
      // Never part of any packet mask; ready value only keeps 'complete' well defined
      assign fifo_rdy[k]                      = 1'b1;
      assign bus.o_tvalid[k]                  = 1'b0;
      assign bus.o_tlast[k]                   = 1'b0;
      assign bus.o_tdata[k*WIDTH +: WIDTH]    = '0;
    end
  end

endmodule

// File: tb/tb_split_stream_fifo_n.sv
// Directed bench: instance A backpressures on full, instance B drops on full.
module tb_split_stream_fifo_n;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n_a, rst_n_b, clear_a, clear_b;
  logic [N-1:0] en_mask, rdy_a, rdy_b;
  logic [W-1:0] tdata;
  logic         tlast, tvalid_a, tvalid_b;

  split_stream_fifo_n_if #(.WIDTH(W), .NUM_OUTPUTS(N)) ifa ();
  split_stream_fifo_n_if #(.WIDTH(W), .NUM_OUTPUTS(N)) ifb ();

  assign ifa.en_mask  = en_mask;
  assign ifa.i_tdata  = tdata;
  assign ifa.i_tlast  = tlast;
  assign ifa.i_tvalid = tvalid_a;
  assign ifa.o_tready = rdy_a;
  assign ifb.en_mask  = en_mask;
  assign ifb.i_tdata  = tdata;
  assign ifb.i_tlast  = tlast;
  assign ifb.i_tvalid = tvalid_b;
  assign ifb.o_tready = rdy_b;

  split_stream_fifo_n #(.WIDTH(W), .NUM_OUTPUTS(N), .FIFO_SIZE(1),
                        .ACTIVE_MASK(4'hF), .DROP_MODE(0))
    dut_a (.clk(clk), .reset_n(rst_n_a), .clear(clear_a), .bus(ifa));

  split_stream_fifo_n #(.WIDTH(W), .NUM_OUTPUTS(N), .FIFO_SIZE(1),
                        .ACTIVE_MASK(4'hF), .DROP_MODE(1))
    dut_b (.clk(clk), .reset_n(rst_n_b), .clear(clear_b), .bus(ifb));

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt, first_stall;

  logic [16:0] exp_beats [8];
  logic [16:0] rec_a [N][32];
  logic [16:0] rec_b [N][32];
  int          cnt_a [N];
  int          cnt_b [N];
  bit          vld_seen_a;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitors: record every completed output handshake
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (ifa.o_tvalid[k]) vld_seen_a = 1'b1;
      if (ifa.o_tvalid[k] && rdy_a[k]) begin
        if (cnt_a[k] < 32) rec_a[k][cnt_a[k]] = {ifa.o_tlast[k], ifa.o_tdata[k*W +: W]};
        cnt_a[k]++;
      end
      if (ifb.o_tvalid[k] && rdy_b[k]) begin
        if (cnt_b[k] < 32) rec_b[k][cnt_b[k]] = {ifb.o_tlast[k], ifb.o_tdata[k*W +: W]};
        cnt_b[k]++;
      end
    end
  end

  task automatic clear_rec();
    for (int k = 0; k < N; k++) begin
      cnt_a[k] = 0;
      cnt_b[k] = 0;
    end
    vld_seen_a = 1'b0;
  endtask

  task automatic fill_exp(input logic [15:0] base, input logic [15:0] step, input int n);
    for (int i = 0; i < 8; i++)
      exp_beats[i] = {(i == n - 1), 16'(base + 16'(i) * step)};
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send exp_beats[0..n-1]; partial suppresses tlast; en_mask changes after beat chg_at
  task automatic send_pkt(input int inst, input int n, input bit partial,
                          input int chg_at, input logic [N-1:0] new_mask);
    for (int i = 0; i < n; i++) begin
      bit done  = 1'b0;
      int guard = 0;
      tdata = exp_beats[i][15:0];
      tlast = (i == n - 1) && !partial;
      if (inst == 0) tvalid_a = 1'b1; else tvalid_b = 1'b1;
      while (!done) begin
        @(negedge clk);
        if ((inst == 0) ? ifa.i_tready : ifb.i_tready) done = 1'b1;
        else begin
          stall_cnt++;
          if (first_stall < 0) first_stall = i;
        end
        @(posedge clk);
        #1;
        guard++;
        if (!done && guard > 200) begin
          check_val("send_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
      if (i == chg_at) en_mask = new_mask;
    end
    tvalid_a = 1'b0;
    tvalid_b = 1'b0;
    tlast    = 1'b0;
  endtask

  task automatic chk_out(input int inst, input int k, input int n, input string tag);
    int c;
    c = (inst == 0) ? cnt_a[k] : cnt_b[k];
    check_val($sformatf("%s_o%0d_count", tag, k), 64'(c), 64'(n));
    for (int i = 0; i < n && i < c && i < 32; i++)
      check_val($sformatf("%s_o%0d_beat%0d", tag, k, i),
                64'((inst == 0) ? rec_a[k][i] : rec_b[k][i]), 64'(exp_beats[i]));
  endtask

  initial begin
    rst_n_a  = 1'b0;
    rst_n_b  = 1'b0;
    clear_a  = 1'b0;
    clear_b  = 1'b0;
    en_mask  = 4'hF;
    rdy_a    = 4'hF;
    rdy_b    = 4'hF;
    tdata    = '0;
    tlast    = 1'b0;
    tvalid_a = 1'b0;
    tvalid_b = 1'b0;
    clear_rec();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_i_tready_a", 64'(ifa.i_tready), 64'd0);
    check_val("rst_i_tready_b", 64'(ifb.i_tready), 64'd0);
    check_val("rst_o_tvalid", 64'(ifa.o_tvalid), 64'd0);
    check_val("rst_o_tlast", 64'(ifa.o_tlast), 64'd0);
    check_val("rst_o_tdata", 64'(ifa.o_tdata), 64'd0);
    check_val("rst_drop_b", ifb.drop_count, 64'd0);
    @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    wait_cyc(2);

    // 1: 3-beat packet to all outputs, no stall
    clear_rec();
    fill_exp(16'h11, 16'h11, 3);
    stall_cnt = 0; first_stall = -1;
    send_pkt(0, 3, 1'b0, -1, 4'hF);
    wait_cyc(5);
    for (int k = 0; k < N; k++) chk_out(0, k, 3, "t1");
    check_val("t1_stalls", 64'(stall_cnt), 64'd0);

    // 2: mask 0101 latched at start; mid-packet change ignored, next packet sees all
    clear_rec();
    en_mask = 4'b0101;
    fill_exp(16'h21, 16'h1, 4);
    send_pkt(0, 4, 1'b0, 0, 4'hF);
    wait_cyc(5);
    chk_out(0, 0, 4, "t2");
    chk_out(0, 1, 0, "t2");
    chk_out(0, 2, 4, "t2");
    chk_out(0, 3, 0, "t2");
    clear_rec();
    fill_exp(16'h25, 16'h1, 2);
    send_pkt(0, 2, 1'b0, -1, 4'hF);
    wait_cyc(5);
    for (int k = 0; k < N; k++) chk_out(0, k, 2, "t2b");

    // 3: o1 blocked, depth-2 FIFO fills after 2 beats and stalls input
    clear_rec();
    rdy_a = 4'b1101;
    fill_exp(16'h31, 16'h1, 4);
    stall_cnt = 0; first_stall = -1;
    fork
      send_pkt(0, 4, 1'b0, -1, 4'hF);
      begin
        wait_cyc(8);
        rdy_a = 4'hF;
      end
    join
    wait_cyc(6);
    check_val("t3_first_stall_beat", 64'(first_stall), 64'd2);
    check_val("t3_stalled", 64'(stall_cnt > 0), 64'd1);
    for (int k = 0; k < N; k++) chk_out(0, k, 4, "t3");
    check_val("t3_drop_a", ifa.drop_count, 64'd0);

    // 5: all outputs disabled, beats discarded at full rate
    clear_rec();
    en_mask = 4'h0;
    fill_exp(16'h51, 16'h1, 5);
    stall_cnt = 0; first_stall = -1;
    send_pkt(0, 5, 1'b0, -1, 4'h0);
    wait_cyc(4);
    check_val("t5_stalls", 64'(stall_cnt), 64'd0);
    check_val("t5_no_valid", 64'(vld_seen_a), 64'd0);
    check_val("t5_drop_a", ifa.drop_count, 64'd0);
    en_mask = 4'hF;

    // 4: drop mode, o3 pre-filled full and excluded from next packet
    rdy_b = 4'b0111;
    fill_exp(16'h71, 16'h1, 2);
    send_pkt(1, 2, 1'b0, -1, 4'hF);
    wait_cyc(4);
    check_val("t4_prefill_drop", ifb.drop_count, 64'd0);
    clear_rec();
    fill_exp(16'h41, 16'h1, 3);
    stall_cnt = 0; first_stall = -1;
    send_pkt(1, 3, 1'b0, -1, 4'hF);
    wait_cyc(4);
    check_val("t4_stalls", 64'(stall_cnt), 64'd0);
    check_val("t4_drop_b", ifb.drop_count, 64'h0001_0000_0000_0000);
    for (int k = 0; k < 3; k++) chk_out(1, k, 3, "t4");
    chk_out(1, 3, 0, "t4");
    rdy_b = 4'hF;
    wait_cyc(4);
    fill_exp(16'h71, 16'h1, 2);
    chk_out(1, 3, 2, "t4_o3_prefill");

    // 6a: clear mid-packet on drop-mode instance keeps drop_count
    rdy_b = 4'h0;
    fill_exp(16'h81, 16'h1, 4);
    send_pkt(1, 2, 1'b1, -1, 4'hF);
    clear_b = 1'b1;
    wait_cyc(1);
    clear_b = 1'b0;
    @(negedge clk);
    check_val("t6_clear_b_valid", 64'(ifb.o_tvalid), 64'd0);
    check_val("t6_clear_b_drop", ifb.drop_count, 64'h0001_0000_0000_0000);
    @(posedge clk);
    #1;
    rdy_b = 4'hF;
    clear_rec();
    fill_exp(16'h91, 16'h1, 2);
    send_pkt(1, 2, 1'b0, -1, 4'hF);
    wait_cyc(5);
    for (int k = 0; k < N; k++) chk_out(1, k, 2, "t6b");

    // 6b: reset mid-packet, then clear mid-packet, then clean packet
    rdy_a = 4'h0;
    fill_exp(16'hA1, 16'h1, 4);
    send_pkt(0, 2, 1'b1, -1, 4'hF);
    rst_n_a = 1'b0;
    @(negedge clk);
    check_val("t6_rst_i_tready", 64'(ifa.i_tready), 64'd0);
    check_val("t6_rst_o_tvalid", 64'(ifa.o_tvalid), 64'd0);
    wait_cyc(2);
    rst_n_a = 1'b1;
    @(negedge clk);
    check_val("t6_post_rst_o_tvalid", 64'(ifa.o_tvalid), 64'd0);
    @(posedge clk);
    #1;
    send_pkt(0, 2, 1'b1, -1, 4'hF);
    clear_a = 1'b1;
    wait_cyc(1);
    clear_a = 1'b0;
    @(negedge clk);
    check_val("t6_clear_a_valid", 64'(ifa.o_tvalid), 64'd0);
    @(posedge clk);
    #1;
    rdy_a = 4'hF;
    clear_rec();
    fill_exp(16'h61, 16'h1, 3);
    send_pkt(0, 3, 1'b0, -1, 4'hF);
    wait_cyc(5);
    for (int k = 0; k < N; k++) chk_out(0, k, 3, "t6a");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
